ucode_sequencer: RTL and testbench

- Microcode sequencer between iFetch and decode. It expands the MULI macro instruction into a stream of ADD micro-ops.
- While a macro is being expanded it drives `control` high, which freezes the fetch PC in its ucode state.
- All non-macro instructions pass through combinationally, unchanged.

---
 rtl/ucode_sequencer_if.sv | 21 ++
 rtl/ucode_sequencer.sv | 126 ++++++++++++
 tb/tb_ucode_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucode_sequencer_if.sv
// Fetch/decode-side signals of the microcode sequencer, grouped so the
// environment (master) and the sequencer (slave) share one bundle.
interface ucode_sequencer_if;
  logic [31:0] instrIn;
  logic        instrValid;
  logic        uopReady;
  logic [31:0] uopOut;
  logic        uopValid;
  logic        control;
  logic        busy;

  modport master (
    output instrIn, instrValid, uopReady,
    input  uopOut, uopValid, control, busy
  );

  modport slave (
    input  instrIn, instrValid, uopReady,
    output uopOut, uopValid, control, busy
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Expands the MULI macro (rd = rs1 * k) into CLR / k x ADD / MOV micro-ops;
// every other instruction passes straight through to decode.
module ucode_sequencer #(
  parameter logic [6:0] MULI_OP     = 7'b0010110,
  parameter logic [6:0] ADD_OP      = 7'b0000001,
  parameter logic [3:0] ZERO_REG    = 4'd0,
  parameter logic [3:0] SCRATCH_REG = 4'd15
) (
  input  logic            clk,
  input  logic            rst,
  ucode_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_ADD  = 2'd2,
    S_MOV  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  rs1_q, rs1_d;
  logic        skip_q, skip_d;

  logic [31:0] uop_out;
  logic        uop_valid;
  logic        control_o;
  logic        is_muli;

  // Fields [16:8] of a MULI word carry no meaning for the expansion.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, bus.instrIn[16:8]};

  function automatic logic [31:0] make_uop(input logic [3:0] rd,
                                           input logic [3:0] rs1,
                                           input logic [3:0] rs2);
    return {ADD_OP, rd, rs1, rs2, 13'b0};
  endfunction

  assign is_muli = bus.instrValid && (bus.instrIn[31:25] == MULI_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= 8'd0;
      rd_q    <= 4'd0;
      rs1_q   <= 4'd0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    skip_d    = 1'b0;
    uop_out   = bus.instrIn;
    uop_valid = 1'b0;
    control_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_muli && !skip_q) begin
          control_o = 1'b1;
          rd_d      = bus.instrIn[24:21];
          rs1_d     = bus.instrIn[20:17];
          count_d   = bus.instrIn[7:0];
          state_d   = S_CLR;
        end else begin
          // The already-expanded macro word is still on the bus during the
          // skip cycle; it must not reach decode as a raw instruction.
          uop_valid = bus.instrValid && !(skip_q && is_muli);
        end
      end

      S_CLR: begin
        uop_out   = make_uop(SCRATCH_REG, ZERO_REG, ZERO_REG);
        uop_valid = 1'b1;
        control_o = 1'b1;
        if (bus.uopReady) begin
          state_d = (count_q != 8'd0) ? S_ADD : S_MOV;
        end
      end

      S_ADD: begin
        uop_out   = make_uop(SCRATCH_REG, SCRATCH_REG, rs1_q);
        uop_valid = 1'b1;
        control_o = 1'b1;
        if (bus.uopReady) begin
          // count is never zero here, so the decrement cannot wrap.
          count_d = count_q - 8'd1;
          state_d = (count_q == 8'd1) ? S_MOV : S_ADD;
        end
      end

      S_MOV: begin
        uop_out   = make_uop(rd_q, SCRATCH_REG, ZERO_REG);
        uop_valid = 1'b1;
        control_o = 1'b1;
        if (bus.uopReady) begin
          state_d = S_IDLE;
          skip_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.uopOut   = uop_out;
  assign bus.uopValid = uop_valid;
  assign bus.control  = control_o;
  assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: a per-cycle vector table plus
// hand-written sequences for backpressure, mid-sequence reset and back-to-back macros.
module tb_ucode_sequencer;

  localparam logic [6:0]  MULI_OP = 7'b0010110;
  localparam logic [6:0]  ADD_OP  = 7'b0000001;
  localparam logic [31:0] NOP     = 32'hC800_0000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] regs [16];

  ucode_sequencer_if bus ();

  ucode_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        ready;
    logic [31:0] exp_out;
    logic        exp_valid;
    logic        chk_valid;
    logic        exp_ctl;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [31:0] uop(input logic [3:0] rd, input logic [3:0] rs1,
                                      input logic [3:0] rs2);
    return {ADD_OP, rd, rs1, rs2, 13'b0};
  endfunction

  function automatic logic [31:0] muli(input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [7:0] k);
    return {MULI_OP, rd, rs1, 9'b0, k};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-file model: applies every transferred ADD uop.
  task automatic xfer_model();
    logic [31:0] w;
    w = bus.uopOut;
    $display("xfer uop=%h", w);
    if (w[31:25] == ADD_OP && w[24:21] != 4'd0)
      regs[w[24:21]] = regs[w[20:17]] + regs[w[16:13]];
  endtask

  // Detect cycle, k+2 uops with decode always ready, then the skip cycle.
  task automatic run_muli(input string tag, input logic [3:0] rd, input logic [3:0] rs1,
                          input logic [7:0] k);
    int n;
    logic ctl_ok;
    logic [31:0] exp;
    bus.instrIn = muli(rd, rs1, k);
    bus.instrValid = 1'b1;
    bus.uopReady = 1'b1;
    #1;
    chk({tag, "_detect_ctl"}, {31'b0, bus.control}, 32'd1);
    chk({tag, "_detect_valid"}, {31'b0, bus.uopValid}, 32'd0);
    tick();
    n = 0;
    ctl_ok = 1'b1;
    for (int c = 0; c < int'(k) + 10 && n < int'(k) + 2; c++) begin
      #1;
      if (!bus.control || !bus.busy) ctl_ok = 1'b0;
      if (bus.uopValid) begin
        if (n == 0) exp = uop(4'd15, 4'd0, 4'd0);
        else if (n == int'(k) + 1) exp = uop(rd, 4'd15, 4'd0);
        else exp = uop(4'd15, 4'd15, rs1);
        chk($sformatf("%s_uop%0d", tag, n), bus.uopOut, exp);
        xfer_model();
        n++;
      end
      tick();
    end
    chk({tag, "_uop_count"}, n, int'(k) + 2);
    chk({tag, "_ctl_held"}, {31'b0, ctl_ok}, 32'd1);
    #1;
    chk({tag, "_skip_ctl"}, {31'b0, bus.control}, 32'd0);
    chk({tag, "_skip_busy"}, {31'b0, bus.busy}, 32'd0);
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    regs[4] = 32'd7;
    regs[5] = 32'd11;
    regs[3] = 32'hDEAD;
    regs[7] = 32'd13;
    regs[9] = 32'd21;
    regs[11] = 32'd100;

    //           instr               v     r     exp_out              ev    cv    ctl   busy
    vecs[0]  = '{NOP,                1'b1, 1'b1, NOP,                 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{NOP,                1'b1, 1'b0, NOP,                 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h1234_5678,      1'b0, 1'b1, 32'h1234_5678,       1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{muli(2, 5, 3),      1'b1, 1'b1, 32'h0,               1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{muli(2, 5, 3),      1'b1, 1'b1, uop(15, 0, 0),       1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{muli(2, 5, 3),      1'b1, 1'b1, uop(15, 15, 5),      1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{muli(2, 5, 3),      1'b1, 1'b1, uop(15, 15, 5),      1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{muli(2, 5, 3),      1'b1, 1'b1, uop(15, 15, 5),      1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{muli(2, 5, 3),      1'b1, 1'b1, uop(2, 15, 0),       1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{muli(2, 5, 3),      1'b1, 1'b1, 32'h0,               1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{NOP,                1'b1, 1'b1, NOP,                 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{muli(3, 4, 0),      1'b1, 1'b1, 32'h0,               1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{muli(3, 4, 0),      1'b1, 1'b1, uop(15, 0, 0),       1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{muli(3, 4, 0),      1'b1, 1'b1, uop(3, 15, 0),       1'b1, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{muli(3, 4, 0),      1'b1, 1'b1, 32'h0,               1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{NOP,                1'b1, 1'b1, NOP,                 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    bus.instrIn = 32'd0;
    bus.instrValid = 1'b0;
    bus.uopReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_valid", {31'b0, bus.uopValid}, 32'd0);
    chk("reset_ctl", {31'b0, bus.control}, 32'd0);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    tick();

    for (int i = 0; i < 16; i++) begin
      bus.instrIn = vecs[i].instr;
      bus.instrValid = vecs[i].valid;
      bus.uopReady = vecs[i].ready;
      #1;
      if (vecs[i].chk_valid)
        chk($sformatf("vec%0d_valid", i), {31'b0, bus.uopValid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_out", i), bus.uopOut, vecs[i].exp_out);
      chk($sformatf("vec%0d_ctl", i), {31'b0, bus.control}, {31'b0, vecs[i].exp_ctl});
      chk($sformatf("vec%0d_busy", i), {31'b0, bus.busy}, {31'b0, vecs[i].exp_busy});
      if (bus.uopValid && bus.uopReady) xfer_model();
      tick();
    end
    chk("model_k3_rd", regs[2], 32'd33);
    chk("model_k0_rd", regs[3], 32'd0);

    // Backpressure: k=2 with uopReady cycling 1,0,0,1.
    begin
      logic [31:0] exp_seq [4];
      logic [31:0] held;
      logic        was_stalled;
      logic        stable_ok;
      logic        ctl_ok;
      logic        pat [4];
      int          n;
      exp_seq[0] = uop(15, 0, 0);
      exp_seq[1] = uop(15, 15, 7);
      exp_seq[2] = uop(15, 15, 7);
      exp_seq[3] = uop(6, 15, 0);
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      bus.instrIn = muli(6, 7, 2);
      bus.instrValid = 1'b1;
      bus.uopReady = 1'b1;
      #1;
      chk("bp_detect_ctl", {31'b0, bus.control}, 32'd1);
      tick();
      n = 0;
      was_stalled = 1'b0;
      stable_ok = 1'b1;
      ctl_ok = 1'b1;
      held = 32'd0;
      for (int c = 0; c < 50 && n < 4; c++) begin
        bus.uopReady = pat[c % 4];
        #1;
        if (!bus.control) ctl_ok = 1'b0;
        if (was_stalled && bus.uopOut !== held) stable_ok = 1'b0;
        if (bus.uopValid && bus.uopReady) begin
          chk($sformatf("bp_uop%0d", n), bus.uopOut, exp_seq[n]);
          xfer_model();
          n++;
          was_stalled = 1'b0;
        end else if (bus.uopValid) begin
          was_stalled = 1'b1;
          held = bus.uopOut;
        end
        tick();
      end
      chk("bp_uop_count", n, 4);
      chk("bp_stable", {31'b0, stable_ok}, 32'd1);
      chk("bp_ctl_held", {31'b0, ctl_ok}, 32'd1);
      bus.uopReady = 1'b1;
      #1;
      chk("bp_skip_ctl", {31'b0, bus.control}, 32'd0);
      tick();
      bus.instrIn = NOP;
      #1;
      chk("bp_no_reexpand", {31'b0, bus.busy}, 32'd0);
      tick();
      chk("model_bp_rd", regs[6], 32'd26);
    end

    // Reset in the middle of a k=200 expansion.
    begin
      int adds;
      bus.instrIn = muli(1, 2, 200);
      bus.instrValid = 1'b1;
      bus.uopReady = 1'b1;
      tick();
      for (int c = 0; c < 10; c++) begin
        #1;
        if (bus.uopValid) xfer_model();
        tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.instrIn = NOP;
      #1;
      chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_mid_ctl", {31'b0, bus.control}, 32'd0);
      chk("rst_mid_valid", {31'b0, bus.uopValid}, 32'd1);
      chk("rst_mid_out", bus.uopOut, NOP);
      adds = 0;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (bus.uopValid && bus.uopOut[31:25] == ADD_OP) adds++;
        tick();
      end
      chk("rst_mid_no_adds", adds, 0);
    end

    // Back-to-back macros separated only by the fetch-advance cycle.
    run_muli("b2b_k1", 4'd8, 4'd9, 8'd1);
    run_muli("b2b_k2", 4'd10, 4'd11, 8'd2);
    bus.instrIn = NOP;
    #1;
    chk("b2b_after_busy", {31'b0, bus.busy}, 32'd0);
    chk("model_b2b_k1", regs[8], 32'd21);
    chk("model_b2b_k2", regs[10], 32'd200);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
